// File: rtl/rv_iommu_pkg.sv
// Shared walker indices and arbiter state encoding for the IOMMU data-structure read path.
package rv_iommu_pkg;

  localparam int unsigned RD_DDT = 0;
  localparam int unsigned RD_PDT = 1;
  localparam int unsigned RD_PTW = 2;
  localparam int unsigned RD_MSI = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rv_iommu_grant_fifo.sv
// In-order record of which walker owns each queued/in-flight read; head names the next R beat's owner.
module rv_iommu_grant_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rv_iommu_mem_rd_arbiter.sv
// Serialises walker reads onto the single-ID ds AR channel and steers in-order R beats back to their owner.
// Define RV_IOMMU_ARB_FIXED_PRIO_EN for fixed priority (walker 0 highest) instead of round-robin.
module rv_iommu_mem_rd_arbiter
  import rv_iommu_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [N_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]       rsp_data_o,
  output logic                        rsp_err_o,
  output logic                        mem_ar_valid_o,
  output logic [ADDR_WIDTH-1:0]       mem_ar_addr_o,
  input  logic                        mem_ar_ready_i,
  input  logic                        mem_r_valid_i,
  input  logic [DATA_WIDTH-1:0]       mem_r_data_i,
  input  logic                        mem_r_err_i,
  output logic                        mem_r_ready_o,
  output logic                        stray_o,
  output logic                        busy_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

  logic [ADDR_WIDTH-1:0] req_addr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_addr
      assign req_addr[gi] = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  stray_q, stray_d;

  logic [IDX_W-1:0]      win;
  logic                  win_found;
  logic                  ar_fire;
  logic                  accept;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [IDX_W-1:0]      fifo_head;
  logic [CNT_W-1:0]      fifo_count;

  assign win_found = |req_valid_i;

`ifdef RV_IOMMU_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req_valid_i[i]) win = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the candidate just after the pointer wins last.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      cand = IDX_W'((int'(rr_q) + k) % int'(N_REQ));
      if (req_valid_i[cand]) win = cand;
    end
  end

  assign rr_d = accept ? win : rr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= IDX_W'(N_REQ - 1);
    else       rr_q <= rr_d;
  end
`endif

  // Full is judged on the pre-pop count, so a same-cycle R beat never frees a slot early.
  assign ar_fire = (state_q == ISSUE) & mem_ar_ready_i;
  assign accept  = win_found & ~fifo_full & ((state_q == IDLE) | ar_fire);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (accept) begin
      state_d = ISSUE;
      addr_d  = req_addr[win];
    end else if (ar_fire) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[win] = 1'b1;
  end

  assign fifo_pop = mem_r_valid_i & ~fifo_empty;

  always_comb begin
    rsp_valid_d = '0;
    if (fifo_pop) rsp_valid_d[fifo_head] = 1'b1;
    rsp_data_d = fifo_pop ? mem_r_data_i : rsp_data_q;
    rsp_err_d  = fifo_pop ? mem_r_err_i  : rsp_err_q;
    stray_d    = mem_r_valid_i & fifo_empty;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      stray_q     <= stray_d;
    end
  end

  rv_iommu_grant_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) u_grant_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .din_i   (win),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign mem_ar_valid_o = (state_q == ISSUE);
  assign mem_ar_addr_o  = addr_q;
  assign mem_r_ready_o  = 1'b1;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;
  assign stray_o        = stray_q;
  assign busy_o         = (state_q == ISSUE) | (fifo_count != '0);

endmodule

// File: tb/tb_rv_iommu_mem_rd_arbiter.sv
// Directed vector bench for rv_iommu_mem_rd_arbiter (default 4 walkers, 4 outstanding reads).
module tb_rv_iommu_mem_rd_arbiter;
  import rv_iommu_pkg::*;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            ar_valid;
  logic [AW-1:0]   ar_addr;
  logic            ar_ready = 1'b0;
  logic            r_valid = 1'b0;
  logic [DW-1:0]   r_data = '0;
  logic            r_err = 1'b0;
  logic            r_ready;
  logic            stray;
  logic            busy;

  logic [AW-1:0]   waddr [N];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign req_addr = {waddr[3], waddr[2], waddr[1], waddr[0]};

  rv_iommu_mem_rd_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_OUTST  (MO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid),
    .req_addr_i     (req_addr),
    .req_ready_o    (req_ready),
    .rsp_valid_o    (rsp_valid),
    .rsp_data_o     (rsp_data),
    .rsp_err_o      (rsp_err),
    .mem_ar_valid_o (ar_valid),
    .mem_ar_addr_o  (ar_addr),
    .mem_ar_ready_i (ar_ready),
    .mem_r_valid_i  (r_valid),
    .mem_r_data_i   (r_data),
    .mem_r_err_i    (r_err),
    .mem_r_ready_o  (r_ready),
    .stray_o        (stray),
    .busy_o         (busy)
  );

  typedef struct {
    logic          rst;
    logic [3:0]    req;
    logic          ar;
    logic          rv;
    logic          re;
    logic [63:0]   rd;
    logic [3:0]    e_rdy;
    logic          e_ar;
    logic [63:0]   e_addr;
    logic [3:0]    e_rsp;
    logic          e_err;
    logic [63:0]   e_data;
    logic          e_stray;
    logic          e_busy;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic rst, logic [3:0] req, logic ar, logic rv, logic re,
                              logic [63:0] rd, logic [3:0] e_rdy, logic e_ar, logic [63:0] e_addr,
                              logic [3:0] e_rsp, logic e_err, logic [63:0] e_data,
                              logic e_stray, logic e_busy);
    vec_t v;
    v.rst = rst; v.req = req; v.ar = ar; v.rv = rv; v.re = re; v.rd = rd;
    v.e_rdy = e_rdy; v.e_ar = e_ar; v.e_addr = e_addr; v.e_rsp = e_rsp;
    v.e_err = e_err; v.e_data = e_data; v.e_stray = e_stray; v.e_busy = e_busy;
    return v;
  endfunction

  function automatic logic [1:0] gnt(int k);
`ifdef RV_IOMMU_ARB_FIXED_PRIO_EN
    return 2'd0;
`else
    return 2'(k % 4);
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge, return at the following falling edge for checking.
  task automatic drive(input logic r, input logic [3:0] rq, input logic ar, input logic rv,
                       input logic re, input logic [63:0] rd);
    @(posedge clk);
    #1;
    rst_i     = r;
    req_valid = rq;
    ar_ready  = ar;
    r_valid   = rv;
    r_err     = re;
    r_data    = rd;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    drive(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_arv", 64'(ar_valid), 64'h0);
    chk("rst_rsp", 64'(rsp_valid), 64'h0);
    chk("rst_rready", 64'(r_ready), 64'h1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) waddr[i] = 64'h8000_0000 + 64'(i) * 64'h800;

    // Ordering/error, single read to walker 2, stray beat.
    tbl[0]  = mk(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0,
                 4'b0000, 1'b0, 64'h0, 4'b0000, 1'b0, 64'h0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 64'h0,
                 4'b0100, 1'b0, 64'h0, 4'b0000, 1'b0, 64'h0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 64'h0,
                 4'b0001, 1'b1, 64'h8000_1000, 4'b0000, 1'b0, 64'h0, 1'b0, 1'b1);
    tbl[3]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0,
                 4'b0000, 1'b1, 64'h8000_0000, 4'b0000, 1'b0, 64'h0, 1'b0, 1'b1);
    tbl[4]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 64'h1111,
                 4'b0000, 1'b0, 64'h0, 4'b0000, 1'b0, 64'h0, 1'b0, 1'b1);
    tbl[5]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 64'h2222,
                 4'b0000, 1'b0, 64'h0, 4'b0100, 1'b1, 64'h1111, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0,
                 4'b0000, 1'b0, 64'h0, 4'b0001, 1'b0, 64'h2222, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 64'h0,
                 4'b0100, 1'b0, 64'h0, 4'b0000, 1'b0, 64'h0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0,
                 4'b0000, 1'b1, 64'h8000_1000, 4'b0000, 1'b0, 64'h0, 1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF,
                 4'b0000, 1'b0, 64'h0, 4'b0000, 1'b0, 64'h0, 1'b0, 1'b1);
    tbl[10] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0,
                 4'b0000, 1'b0, 64'h0, 4'b0100, 1'b0, 64'hDEAD_BEEF, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 64'h5555,
                 4'b0000, 1'b0, 64'h0, 4'b0000, 1'b0, 64'h0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0,
                 4'b0000, 1'b0, 64'h0, 4'b0000, 1'b0, 64'h0, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0,
                 4'b0000, 1'b0, 64'h0, 4'b0000, 1'b0, 64'h0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].ar, tbl[i].rv, tbl[i].re, tbl[i].rd);
      $display("vec %0d: req=%b rdy=%b ar=%b addr=%h rsp=%b err=%b stray=%b busy=%b",
               i, tbl[i].req, req_ready, ar_valid, ar_addr, rsp_valid, rsp_err, stray, busy);
      chk("tbl_rdy", 64'(req_ready), 64'(tbl[i].e_rdy));
      chk("tbl_arv", 64'(ar_valid), 64'(tbl[i].e_ar));
      if (tbl[i].e_ar) chk("tbl_addr", ar_addr, tbl[i].e_addr);
      chk("tbl_rsp", 64'(rsp_valid), 64'(tbl[i].e_rsp));
      if (tbl[i].e_rsp != 4'b0000) begin
        chk("tbl_err", 64'(rsp_err), 64'(tbl[i].e_err));
        chk("tbl_data", rsp_data, tbl[i].e_data);
      end
      chk("tbl_stray", 64'(stray), 64'(tbl[i].e_stray));
      chk("tbl_busy", 64'(busy), 64'(tbl[i].e_busy));
      chk("tbl_rready", 64'(r_ready), 64'h1);
    end

    // Fairness with all walkers requesting and beats returning two cycles behind.
    reset_dut();
    for (int k = 0; k < 13; k++) begin
      drive(1'b0, (k < 10) ? 4'b1111 : 4'b0000, 1'b1, (k >= 2 && k < 12), 1'b0,
            64'hA000 + 64'(k));
      $display("rr %0d: rdy=%b ar=%b rsp=%b", k, req_ready, ar_valid, rsp_valid);
      chk("rr_rdy", 64'(req_ready), (k < 10) ? 64'(4'b0001 << gnt(k)) : 64'h0);
      chk("rr_arv", 64'(ar_valid), 64'(k >= 1 && k <= 10));
      if (k >= 1 && k <= 10) chk("rr_addr", ar_addr, waddr[gnt(k - 1)]);
      if (k >= 3) begin
        chk("rr_rsp", 64'(rsp_valid), 64'(4'b0001 << gnt(k - 3)));
        chk("rr_data", rsp_data, 64'hA000 + 64'(k - 1));
      end else begin
        chk("rr_rsp", 64'(rsp_valid), 64'h0);
      end
    end

    // Grant FIFO full: four accepts, then blocked until a beat pops (pre-pop full still blocks).
    reset_dut();
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 4'b0010, 1'b1, (k == 6), 1'b0, 64'hF0);
      $display("full %0d: rdy=%b busy=%b", k, req_ready, busy);
      chk("full_rdy", 64'(req_ready), (k < 4 || k == 7) ? 64'h2 : 64'h0);
      chk("full_busy", 64'(busy), (k >= 1) ? 64'h1 : 64'h0);
      if (k == 7) chk("full_rsp", 64'(rsp_valid), 64'h2);
    end

    // AR stall: valid/address held for 10 cycles, then back-to-back accept on the handshake.
    reset_dut();
    drive(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("stall_rdy0", 64'(req_ready), 64'h8);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 64'h0);
      $display("stall %0d: ar=%b addr=%h rdy=%b", k, ar_valid, ar_addr, req_ready);
      chk("stall_arv", 64'(ar_valid), 64'h1);
      chk("stall_addr", ar_addr, waddr[3]);
      chk("stall_rdy", 64'(req_ready), 64'h0);
    end
    drive(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("stall_fire_addr", ar_addr, waddr[3]);
    chk("stall_b2b_rdy", 64'(req_ready), 64'h1);
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("stall_next_arv", 64'(ar_valid), 64'h1);
    chk("stall_next_addr", ar_addr, waddr[0]);

    // Reset with two reads in flight: their late beats are strays, nobody gets a response.
    reset_dut();
    drive(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("sr_rdy0", 64'(req_ready), 64'h1);
    drive(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("sr_rdy1", 64'(req_ready), 64'h2);
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("sr_busy", 64'(busy), 64'h1);
    drive(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("sr_rst_busy", 64'(busy), 64'h0);
    chk("sr_rst_arv", 64'(ar_valid), 64'h0);
    drive(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 64'h77);
    chk("sr_stray_a", 64'(stray), 64'h0);
    drive(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 64'h78);
    $display("stray beat 1: stray=%b rsp=%b", stray, rsp_valid);
    chk("sr_stray_b", 64'(stray), 64'h1);
    chk("sr_rsp_b", 64'(rsp_valid), 64'h0);
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0);
    $display("stray beat 2: stray=%b rsp=%b", stray, rsp_valid);
    chk("sr_stray_c", 64'(stray), 64'h1);
    chk("sr_rsp_c", 64'(rsp_valid), 64'h0);
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("sr_stray_d", 64'(stray), 64'h0);
    chk("sr_busy_d", 64'(busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
